// File: rtl/adder_pipe_param.sv
// rtl/adder_pipe_param.sv - pipelined add/subtract unit, one registered carry slice per stage
// Operand slices are skewed in and result slices deskewed out so every stage advances together.
module adder_pipe_param #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int SW = WIDTH / STAGES;

   logic              advance;
   logic [WIDTH-1:0]  b_eff;
   logic              c0;
   logic [STAGES-1:0] vld_r;
   logic [STAGES-1:0] vld_nxt;
   logic [STAGES-1:0] carry_r;

   // A full output that is not being taken freezes the whole pipe.
   assign advance   = !vld_r[STAGES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_r[STAGES-1];
   assign cout      = carry_r[STAGES-1];
   assign b_eff     = sub ? ~in2 : in2;
   assign c0        = sub ? ~cin : cin;

   if (STAGES == 1) begin : g_vld_one
      assign vld_nxt = in_valid;
   end else begin : g_vld_many
      assign vld_nxt = {vld_r[STAGES-2:0], in_valid};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_r <= '0;
      end else if (advance) begin
         vld_r <= vld_nxt;
      end
   end

   for (genvar j = 0; j < STAGES; j++) begin : g_slice
      localparam int RD = STAGES - j;

      logic [SW-1:0]          a_at;
      logic [SW-1:0]          b_at;
      logic                   c_at;
      logic [SW:0]            part;
      logic                   carry_q;
      logic [RD-1:0][SW-1:0]  r_dly;
      logic [RD-1:0][SW-1:0]  r_nxt;

      // Slice j waits j cycles so it meets the carry coming out of slice j-1.
      if (j == 0) begin : g_head
         assign a_at = in1[SW-1:0];
         assign b_at = b_eff[SW-1:0];
         assign c_at = c0;
      end else begin : g_skew
         logic [j-1:0][SW-1:0] a_dly;
         logic [j-1:0][SW-1:0] b_dly;
         logic [j-1:0][SW-1:0] a_nxt;
         logic [j-1:0][SW-1:0] b_nxt;

         if (j == 1) begin : g_one
            assign a_nxt = in1[j*SW +: SW];
            assign b_nxt = b_eff[j*SW +: SW];
         end else begin : g_many
            assign a_nxt = {a_dly[j-2:0], in1[j*SW +: SW]};
            assign b_nxt = {b_dly[j-2:0], b_eff[j*SW +: SW]};
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_dly <= '0;
               b_dly <= '0;
            end else if (advance) begin
               a_dly <= a_nxt;
               b_dly <= b_nxt;
            end
         end

         assign a_at = a_dly[j-1];
         assign b_at = b_dly[j-1];
         assign c_at = carry_r[j-1];
      end

      assign part = {1'b0, a_at} + {1'b0, b_at} + {{SW{1'b0}}, c_at};

      // Result slice j then waits STAGES-1-j cycles so all slices leave together.
      if (RD == 1) begin : g_r_one
         assign r_nxt = part[SW-1:0];
      end else begin : g_r_many
         assign r_nxt = {r_dly[RD-2:0], part[SW-1:0]};
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            carry_q <= 1'b0;
            r_dly   <= '0;
         end else if (advance) begin
            carry_q <= part[SW];
            r_dly   <= r_nxt;
         end
      end

      assign carry_r[j]      = carry_q;
      assign sum[j*SW +: SW] = r_dly[RD-1];

      if (j == STAGES - 1) begin : g_tail
         logic ovf_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= (a_at[SW-1] == b_at[SW-1]) && (part[SW-1] != a_at[SW-1]);
            end
         end

         assign overflow = ovf_q;
      end
   end
endmodule

// File: tb/tb_adder_pipe_param.sv
// tb/tb_adder_pipe_param.sv - scoreboard bench for adder_pipe_param at STAGES 1, 2, 4 and 8
module tb_adder_pipe_param;
   localparam int W = 32;

   logic clk = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   done [4];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Exact integer arithmetic; carry, borrow and overflow come from range tests on the true result.
   function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      longint ua, ub, sa, sb, cl, ur, sr;
      logic   co, ov;
      logic [W-1:0] r;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      cl = c;
      if (s) begin
         ur = ua - ub - cl;
         sr = sa - sb - cl;
         co = (ur >= 0);
      end else begin
         ur = ua + ub + cl;
         sr = sa + sb + cl;
         co = (ur >= 64'sh1_0000_0000);
      end
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r  = ur[W-1:0];
      return {ov, co, r};
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int ST = 1 << gi;

      logic         reset, in_valid, in_ready, cin, sub;
      logic         out_valid, out_ready, cout, overflow;
      logic [W-1:0] in1, in2, sum;
      logic [33:0]  exp_q [$];
      int           n_out = 0;
      logic         held = 1'b0;
      logic [33:0]  held_val;

      adder_pipe_param #(.WIDTH(W), .STAGES(ST)) dut (
         .clk      (clk),
         .reset    (reset),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .in1      (in1),
         .in2      (in2),
         .cin      (cin),
         .sub      (sub),
         .out_valid(out_valid),
         .out_ready(out_ready),
         .sum      (sum),
         .cout     (cout),
         .overflow (overflow)
      );

      always @(negedge clk) begin
         if (reset) begin
            held = 1'b0;
         end else begin
            chk($sformatf("S%0d in_ready", ST), in_ready, !out_valid || out_ready);
            if (held)
               chk($sformatf("S%0d stall_hold", ST), {out_valid, overflow, cout, sum}, {1'b1, held_val});
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL S%0d spurious_out: got 0x%0h, expected no output", ST,
                           {overflow, cout, sum});
               end else begin
                  chk($sformatf("S%0d result", ST), {overflow, cout, sum}, exp_q.pop_front());
               end
            end
            held     = out_valid && !out_ready;
            held_val = {overflow, cout, sum};
         end
      end

      task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s, input logic ordy, output bit acc);
         @(posedge clk);
         #1;
         in_valid  = v;
         in1       = a;
         in2       = b;
         cin       = c;
         sub       = s;
         out_ready = ordy;
         @(negedge clk);
         acc = in_valid && in_ready && !reset;
         if (acc) exp_q.push_back(model(a, b, c, s));
      endtask

      task automatic drain();
         bit acc;
         for (int k = 0; k < ST + 10 && exp_q.size() != 0; k++)
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         #1;
      endtask

      task automatic single_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s, input logic [33:0] want);
         bit acc;
         int lat;
         drive(1'b1, a, b, c, s, 1'b1, acc);
         chk($sformatf("%s accept", name), acc, 1'b1);
         lat = -1;
         for (int k = 1; k <= ST + 3 && lat < 0; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (out_valid) begin
               lat = k;
               chk(name, {overflow, cout, sum}, want);
            end
         end
         chk($sformatf("%s latency", name), lat, ST);
      endtask

      initial begin
         bit acc;
         int sent, n0;
         reset = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
         cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("S%0d reset_state", ST), {out_valid, in_ready, overflow, cout, sum},
             {1'b0, 1'b1, 34'h0});
         @(posedge clk);
         #1;
         reset = 1'b0;

         single_op($sformatf("S%0d add_carry", ST), 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0});
         single_op($sformatf("S%0d sub_ovf", ST), 32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
         single_op($sformatf("S%0d sub_5_3", ST), 32'd5, 32'd3, 1'b0, 1'b1, {1'b0, 1'b1, 32'h2});
         single_op($sformatf("S%0d sub_3_5", ST), 32'd3, 32'd5, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});

         // Reset with operations in flight: nothing accepted before it may ever emerge.
         sent = 0;
         for (int k = 0; k < 10 && sent < 3; k++) begin
            drive(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'($urandom()), 1'b1, acc);
            if (acc) sent++;
         end
         #1;
         reset    = 1'b1;
         in_valid = 1'b0;
         exp_q.delete();
         #1;
         chk($sformatf("S%0d mid_reset", ST), {out_valid, overflow, cout, sum}, 35'h0);
         @(posedge clk);
         #1;
         reset = 1'b0;
         for (int k = 0; k < ST + 3; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            chk($sformatf("S%0d post_reset_quiet", ST), out_valid, 1'b0);
         end

         // Back-pressure: eight ops streamed while the consumer stalls in cycles 5-9.
         sent = 0;
         n0   = n_out;
         for (int cyc = 1; cyc <= 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
            drive(sent < 8, $urandom(), $urandom(), 1'($urandom()), 1'($urandom()),
                  !(cyc >= 5 && cyc <= 9), acc);
            if (acc) sent++;
            if (cyc == 9) chk($sformatf("S%0d bp_full_in_ready", ST), in_ready, 1'b0);
         end
         #1;
         chk($sformatf("S%0d bp_sent", ST), sent, 8);
         chk($sformatf("S%0d bp_delivered", ST), n_out - n0, 8);

         // Both sides always ready: one accept every cycle.
         sent = 0;
         n0   = n_out;
         for (int k = 0; k < 200; k++) begin
            drive(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'($urandom()), 1'b1, acc);
            if (acc) sent++;
         end
         drain();
         chk($sformatf("S%0d thru_accept", ST), sent, 200);
         chk($sformatf("S%0d thru_delivered", ST), n_out - n0, 200);

         sent = 0;
         for (int k = 0; k < 60000 && sent < 10000; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom(), $urandom(), 1'($urandom()),
                  1'($urandom()), $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
         end
         drain();
         chk($sformatf("S%0d rand_sent", ST), sent, 10000);
         chk($sformatf("S%0d drain_empty", ST), exp_q.size(), 0);
         done[gi] = 1'b1;
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      while (!(done[0] && done[1] && done[2] && done[3]) && cyc < 80000) begin
         @(posedge clk);
         cyc++;
      end
      chk("all_done", {done[3], done[2], done[1], done[0]}, 4'hF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
